rhd_spi_responder: RTL

- Synthesizable model of the chip end of the RHD2000 SPI link driven by the rhd acquisition master: samples CS/SCLK/MOSI, decodes 16-bit commands, drives MISO.
- Used in rhd_axi_tb block designs and hardware loopback builds so the master's MISO delay compensation and packetizing can be checked against known data.
- One instance per modelled chip.

---
 rtl/rhd_pkg.sv | 45 ++++
 rtl/rhd_sync_edge.sv | 31 +++
 rtl/rhd_spi_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rhd_pkg.sv
// Shared command encodings, register map constants and payload types for the
// RHD2000 SPI responder model.
package rhd_pkg;

  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned SAMP_W      = 10;
  localparam int unsigned NUM_WR_REGS = 18;

  localparam logic [1:0] CMD_CONVERT = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_READ    = 2'b11;

  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_CLEAR     = 16'h6A00;

  localparam logic [5:0] WR_REG_LAST  = 6'd17;
  localparam logic [5:0] ROM_ADDR_I   = 6'd40;
  localparam logic [5:0] ROM_ADDR_N0  = 6'd41;
  localparam logic [5:0] ROM_ADDR_T   = 6'd42;
  localparam logic [5:0] ROM_ADDR_A   = 6'd43;
  localparam logic [5:0] ROM_ADDR_N1  = 6'd44;
  localparam logic [5:0] ADDR_CHIP_ID = 6'd63;

  typedef logic [15:0] result_t;

  typedef struct packed {
    logic [1:0] prefix;
    logic [5:0] addr;
    logic [7:0] data;
  } cmd_t;

  // Read-only "INTAN" signature registers
  function automatic logic [7:0] rom_lookup(input logic [5:0] addr);
    case (addr)
      ROM_ADDR_I:  rom_lookup = 8'h49;
      ROM_ADDR_N0: rom_lookup = 8'h4E;
      ROM_ADDR_T:  rom_lookup = 8'h54;
      ROM_ADDR_A:  rom_lookup = 8'h41;
      ROM_ADDR_N1: rom_lookup = 8'h4E;
      default:     rom_lookup = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rhd_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses; the pulses line up
// with a signal delayed by STAGES+1 flops.
module rhd_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      o_rise <= r_sync[STAGES-1] & ~r_prev;
      o_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

endmodule

// File: rtl/rhd_spi_responder.sv
// Chip-side model of an RHD2000 SPI link: decodes 16-bit commands and returns
// results two frames later on MISO.
module rhd_spi_responder
  import rhd_pkg::*;
#(
  parameter int unsigned CHIP_ID      = 1,
  parameter int unsigned NUM_CHANNELS = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        frame_valid,
  output logic [15:0] rx_word,
  output logic        short_frame
);

  logic w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall, w_mosi;

  logic [SYNC_STAGES:0]  r_mosi_sync;
  logic                  r_in_frame;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [14:0]           r_tx_shift;
  logic [15:0]           r_rx_shift;
  result_t               r_res0;
  result_t               r_tx_word;
  logic [SAMP_W-1:0]     r_samp_cnt;
  logic [7:0]            r_regs [NUM_WR_REGS];

  cmd_t                  w_cmd;
  result_t               w_result;
  logic [7:0]            w_rd_data;
  logic                  w_full;

  rhd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_d    (CS),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  rhd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_d    (SCLK),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // MOSI gets one extra flop so it lines up with the registered SCLK edge pulses
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-1:0], MOSI};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES];

  assign w_cmd  = cmd_t'(r_rx_shift);
  assign w_full = (r_bit_cnt == CNT_W'(FRAME_BITS));

  always_comb begin
    w_rd_data = 8'h00;
    if (w_cmd.addr <= WR_REG_LAST)       w_rd_data = r_regs[w_cmd.addr[4:0]];
    else if (w_cmd.addr == ADDR_CHIP_ID) w_rd_data = 8'(CHIP_ID);
    else                                 w_rd_data = rom_lookup(w_cmd.addr);
  end

  // Result of the command currently held in the receive shifter
  always_comb begin
    w_result = '0;
    case (w_cmd.prefix)
      CMD_CONVERT: begin
        if (32'(w_cmd.addr) < NUM_CHANNELS) w_result = {w_cmd.addr, r_samp_cnt};
      end
      CMD_WRITE: w_result = {8'hFF, w_cmd.data};
      CMD_READ:  w_result = {8'h00, w_rd_data};
      default: begin
        case (r_rx_shift)
          CMD_CALIBRATE, CMD_CLEAR: w_result = '0;
          default:                  w_result = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      MISO        <= 1'b0;
      frame_valid <= 1'b0;
      rx_word     <= '0;
      short_frame <= 1'b0;
      r_in_frame  <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_res0      <= '0;
      r_tx_word   <= '0;
      r_samp_cnt  <= '0;
      for (int i = 0; i < NUM_WR_REGS; i++) r_regs[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      short_frame <= 1'b0;
      // CS rise takes priority over any SCLK edge seen in the same cycle
      if (w_cs_rise) begin
        r_in_frame <= 1'b0;
        if (w_full) begin
          rx_word     <= r_rx_shift;
          frame_valid <= 1'b1;
          r_tx_word   <= r_res0;
          r_res0      <= w_result;
          if (w_cmd.prefix == CMD_WRITE && w_cmd.addr <= WR_REG_LAST)
            r_regs[w_cmd.addr[4:0]] <= w_cmd.data;
          if (r_rx_shift == CMD_CLEAR)
            r_samp_cnt <= '0;
          else if (w_cmd.prefix == CMD_CONVERT && w_cmd.addr == 6'd0)
            r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
        end else begin
          short_frame <= 1'b1;
        end
      end else if (w_cs_fall) begin
        r_in_frame <= 1'b1;
        r_bit_cnt  <= '0;
        r_tx_shift <= r_tx_word[14:0];
        MISO       <= r_tx_word[15];
      end else if (r_in_frame) begin
        if (w_sclk_rise && !w_full) begin
          r_rx_shift <= {r_rx_shift[14:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
        end
        if (w_sclk_fall) begin
          if (!w_full) begin
            MISO       <= r_tx_shift[14];
            r_tx_shift <= {r_tx_shift[13:0], 1'b0};
          end else begin
            MISO <= 1'b0;
          end
        end
      end
    end
  end

endmodule
